// File: rtl/seg_capture.sv
// Samples a multiplexed 2-digit 7-segment bus, debounces each strobe and rebuilds the 0..99 value.
// Optional SEG_CAPTURE_CHG_ONLY_EN: suppress num_vld when a completed frame repeats the current num.
module seg_capture #(
  parameter int STABLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [6:0]       dig,
  input  logic [7:0]       an,
  input  logic             err_clr,
  output logic [6:0]       num,
  output logic             num_vld,
  output logic [3:0]       d0,
  output logic [3:0]       d1,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0]       STB     = 4'(STABLE);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [7:0]       an_q, an_d;
  logic [6:0]       dig_q, dig_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [3:0]       d0_q, d0_d, d1_q, d1_d;
  logic             u_ok_q, u_ok_d, t_ok_q, t_ok_d;
  logic [6:0]       num_q, num_d;
  logic             num_vld_q, num_vld_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`ifdef SEG_CAPTURE_CHG_ONLY_EN
  logic             seen_q, seen_d;
`endif

  logic       same;
  logic       code_ok;
  logic [3:0] digit;
  logic       err_evt;
  logic [6:0] sum;

  // Returns {valid, digit} for an active-low a..g cathode pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'b1_0000;
      7'b1001111: decode = 5'b1_0001;
      7'b0010010: decode = 5'b1_0010;
      7'b0000110: decode = 5'b1_0011;
      7'b1001100: decode = 5'b1_0100;
      7'b0100100: decode = 5'b1_0101;
      7'b0100000: decode = 5'b1_0110;
      7'b0001111: decode = 5'b1_0111;
      7'b0000000: decode = 5'b1_1000;
      7'b0001100: decode = 5'b1_1001;
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    an_d  = an;
    dig_d = dig;
    same  = ({an, dig} == {an_q, dig_q});
    if (same) cnt_d = (cnt_q == STB) ? cnt_q : cnt_q + 4'd1;
    else      cnt_d = 4'd1;
    // A run is accepted only on the edge where it first reaches STABLE.
    acc_d = (cnt_d == STB) && !(same && (cnt_q == STB));
  end

  always_comb begin
    {code_ok, digit} = decode(dig_q);
    sum       = ({3'b000, d1_q} * 7'd10) + {3'b000, d0_q};
    d0_d      = d0_q;
    d1_d      = d1_q;
    u_ok_d    = u_ok_q;
    t_ok_d    = t_ok_q;
    num_d     = num_q;
    num_vld_d = 1'b0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    err_evt   = 1'b0;
`ifdef SEG_CAPTURE_CHG_ONLY_EN
    seen_d    = seen_q;
`endif

    if (u_ok_q && t_ok_q) begin
      num_d  = sum;
`ifdef SEG_CAPTURE_CHG_ONLY_EN
      num_vld_d = !seen_q || (sum != num_q);
      seen_d    = 1'b1;
`else
      num_vld_d = 1'b1;
`endif
      u_ok_d = 1'b0;
      t_ok_d = 1'b0;
    end

    // Slot updates come after the frame clear so a same-edge set survives.
    if (acc_q) begin
      case (an_q)
        8'hFE: begin
          if (code_ok) begin
            d0_d   = digit;
            u_ok_d = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
        end
        8'hFD: begin
          if (code_ok) begin
            d1_d   = digit;
            t_ok_d = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
        end
        8'hFF:   err_evt = 1'b0;
        default: err_evt = 1'b1;
      endcase
    end

    if (err_evt) begin
      err_d  = 1'b1;
      u_ok_d = 1'b0;
      t_ok_d = 1'b0;
      if (err_clr)               err_cnt_d = ERR_ONE;
      else if (err_cnt_q != '1)  err_cnt_d = err_cnt_q + ERR_ONE;
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      an_q      <= 8'hFF;
      dig_q     <= 7'h7F;
      cnt_q     <= 4'd0;
      acc_q     <= 1'b0;
      d0_q      <= 4'd0;
      d1_q      <= 4'd0;
      u_ok_q    <= 1'b0;
      t_ok_q    <= 1'b0;
      num_q     <= 7'd0;
      num_vld_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef SEG_CAPTURE_CHG_ONLY_EN
      seen_q    <= 1'b0;
`endif
    end else begin
      an_q      <= an_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      u_ok_q    <= u_ok_d;
      t_ok_q    <= t_ok_d;
      num_q     <= num_d;
      num_vld_q <= num_vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef SEG_CAPTURE_CHG_ONLY_EN
      seen_q    <= seen_d;
`endif
    end
  end

  assign num     = num_q;
  assign num_vld = num_vld_q;
  assign d0      = d0_q;
  assign d1      = d1_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: two instances (STABLE=1 and STABLE=3) share one stimulus stream and are
// checked every cycle against a strobe/frame-level reference model, plus literal scenario results.
module tb_seg_capture;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] dig = 7'h7F;
  logic [7:0] an = 8'hFF;
  logic       err_clr = 1'b0;

  logic [6:0] num_o [2];
  logic       vld_o [2];
  logic [3:0] d0_o [2];
  logic [3:0] d1_o [2];
  logic       err_o [2];
  logic [7:0] ecnt_o [2];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 ck = ~ck;

  seg_capture #(.STABLE(1), .ERR_W(8)) u0 (
    .ck(ck), .rst_n(rst_n), .dig(dig), .an(an), .err_clr(err_clr),
    .num(num_o[0]), .num_vld(vld_o[0]), .d0(d0_o[0]), .d1(d1_o[0]),
    .err(err_o[0]), .err_cnt(ecnt_o[0])
  );

  seg_capture #(.STABLE(3), .ERR_W(8)) u1 (
    .ck(ck), .rst_n(rst_n), .dig(dig), .an(an), .err_clr(err_clr),
    .num(num_o[1]), .num_vld(vld_o[1]), .d0(d0_o[1]), .d1(d1_o[1]),
    .err(err_o[1]), .err_cnt(ecnt_o[1])
  );

  // Segment table for digits 0..9, active-low a..g.
  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

  // Reference model: run length kept as an unbounded count, a strobe takes effect one
  // edge after it is accepted, and a complete frame publishes one edge after that.
  int          m_run [2];
  logic [14:0] m_last [2];
  bit          m_pend [2];
  logic [14:0] m_psmp [2];
  int          m_units [2];
  int          m_tens [2];
  bit          m_uh [2];
  bit          m_th [2];
  int          m_num [2];
  bit          m_vld [2];
  bit          m_err [2];
  int          m_ecnt [2];
  bit          m_seen [2];

  function automatic int decodeDigit(input logic [6:0] d);
    for (int k = 0; k < 10; k++) if (codes[k] == d) return k;
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_last[i] = {8'hFF, 7'h7F}; m_pend[i] = 0; m_psmp[i] = '0;
      m_units[i] = 0; m_tens[i] = 0; m_uh[i] = 0; m_th[i] = 0;
      m_num[i] = 0; m_vld[i] = 0; m_err[i] = 0; m_ecnt[i] = 0; m_seen[i] = 0;
    end
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int       stab;
      int       newnum;
      int       dv;
      bit       evt;
      logic [7:0]  pa;
      logic [14:0] s;
      stab = (i == 0) ? 1 : 3;
      evt = 0;
      m_vld[i] = 0;
      if (m_uh[i] && m_th[i]) begin
        newnum = m_tens[i] * 10 + m_units[i];
`ifdef SEG_CAPTURE_CHG_ONLY_EN
        m_vld[i] = !m_seen[i] || (newnum != m_num[i]);
`else
        m_vld[i] = 1;
`endif
        m_num[i] = newnum;
        m_seen[i] = 1;
        m_uh[i] = 0;
        m_th[i] = 0;
      end
      if (m_pend[i]) begin
        pa = m_psmp[i][14:7];
        dv = decodeDigit(m_psmp[i][6:0]);
        if (pa == 8'hFE && dv >= 0) begin
          m_units[i] = dv; m_uh[i] = 1;
        end else if (pa == 8'hFD && dv >= 0) begin
          m_tens[i] = dv; m_th[i] = 1;
        end else if (pa != 8'hFF) begin
          evt = 1;
        end
      end
      if (evt) begin
        m_err[i] = 1;
        m_ecnt[i] = err_clr ? 1 : ((m_ecnt[i] < 255) ? m_ecnt[i] + 1 : 255);
        m_uh[i] = 0;
        m_th[i] = 0;
      end else if (err_clr) begin
        m_err[i] = 0;
        m_ecnt[i] = 0;
      end
      s = {an, dig};
      m_run[i] = (s == m_last[i]) ? m_run[i] + 1 : 1;
      m_last[i] = s;
      m_pend[i] = (m_run[i] == stab);
      m_psmp[i] = s;
    end
  endtask

  task automatic checkOutput(input string name, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s u%0d at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput("num",     i, int'(num_o[i]),  m_num[i]);
      checkOutput("num_vld", i, int'(vld_o[i]),  int'(m_vld[i]));
      checkOutput("d0",      i, int'(d0_o[i]),   m_units[i]);
      checkOutput("d1",      i, int'(d1_o[i]),   m_tens[i]);
      checkOutput("err",     i, int'(err_o[i]),  int'(m_err[i]));
      checkOutput("err_cnt", i, int'(ecnt_o[i]), m_ecnt[i]);
    end
  endtask

  // Pins both the model and the DUT to a hand-derived value.
  task automatic checkLiteral(input string name, input int inst, input int dut_v,
                              input int model_v, input int exp);
    checkOutput({name, "_dut"}, inst, dut_v, exp);
    checkOutput({name, "_model"}, inst, model_v, exp);
  endtask

  task automatic tick(input logic [7:0] a, input logic [6:0] d, input logic c);
    @(posedge ck);
    modelStep();
    #1;
    an = a;
    dig = d;
    err_clr = c;
    @(negedge ck);
    compareAll();
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [6:0] d, input logic c, input int n);
    for (int k = 0; k < n; k++) tick(a, d, (k == 0) ? c : 1'b0);
  endtask

  task automatic pulseReset();
    @(posedge ck);
    modelStep();
    #2 rst_n = 1'b0;
    modelReset();
    @(negedge ck);
    compareAll();
    @(posedge ck);
    modelStep();
    #2 rst_n = 1'b1;
    @(negedge ck);
    compareAll();
  endtask

  initial begin
    modelReset();
    rst_n = 1'b0;
    applyStimulus(8'hFF, 7'h7F, 1'b0, 3);
    @(posedge ck);
    modelStep();
    #2 rst_n = 1'b1;
    @(negedge ck);
    compareAll();
    for (int i = 0; i < 2; i++) begin
      checkLiteral("rst_num", i, int'(num_o[i]), m_num[i], 0);
      checkLiteral("rst_vld", i, int'(vld_o[i]), int'(m_vld[i]), 0);
      checkLiteral("rst_err_cnt", i, int'(ecnt_o[i]), m_ecnt[i], 0);
    end

    // Alternating 3/1 every cycle: only the STABLE=1 instance sees 13.
    for (int k = 0; k < 10; k++) tick((k % 2 == 0) ? 8'hFE : 8'hFD, (k % 2 == 0) ? codes[3] : codes[1], 1'b0);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("alt_num", 0, int'(num_o[0]), m_num[0], 13);
    checkLiteral("alt_d0", 0, int'(d0_o[0]), m_units[0], 3);
    checkLiteral("alt_d1", 0, int'(d1_o[0]), m_tens[0], 1);
    checkLiteral("alt_err", 0, int'(err_o[0]), int'(m_err[0]), 0);
    checkLiteral("alt_num", 1, int'(num_o[1]), m_num[1], 0);

    // Short units run rejected by STABLE=3, then a full run completes 47.
    applyStimulus(8'hFE, codes[7], 1'b0, 2);
    applyStimulus(8'hFD, codes[4], 1'b0, 5);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("short_num", 1, int'(num_o[1]), m_num[1], 0);
    applyStimulus(8'hFE, codes[7], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("n47", 0, int'(num_o[0]), m_num[0], 47);
    checkLiteral("n47", 1, int'(num_o[1]), m_num[1], 47);

    // Bad code aborts the frame after tens=5.
    applyStimulus(8'hFD, codes[5], 1'b0, 3);
    applyStimulus(8'hFE, 7'h7F, 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 3);
    checkLiteral("bad_err", 1, int'(err_o[1]), int'(m_err[1]), 1);
    checkLiteral("bad_cnt", 1, int'(ecnt_o[1]), m_ecnt[1], 1);
    checkLiteral("bad_num", 1, int'(num_o[1]), m_num[1], 47);
    applyStimulus(8'hFE, codes[2], 1'b0, 3);
    applyStimulus(8'hFD, codes[6], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("n62", 0, int'(num_o[0]), m_num[0], 62);
    checkLiteral("n62", 1, int'(num_o[1]), m_num[1], 62);

    // Both digits enabled, then err_clr landing on the STABLE=3 error edge.
    applyStimulus(8'hFC, codes[0], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 3);
    checkLiteral("fc_cnt", 1, int'(ecnt_o[1]), m_ecnt[1], 2);
    applyStimulus(8'hFC, codes[3], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b1, 4);
    checkLiteral("clr_err", 1, int'(err_o[1]), int'(m_err[1]), 1);
    checkLiteral("clr_cnt", 1, int'(ecnt_o[1]), m_ecnt[1], 1);
    checkLiteral("clr_err", 0, int'(err_o[0]), int'(m_err[0]), 0);
    checkLiteral("clr_cnt", 0, int'(ecnt_o[0]), m_ecnt[0], 0);

    // Saturation of the error counter.
    for (int k = 0; k < 260; k++) begin
      applyStimulus(8'hFC, codes[1], 1'b0, 3);
      applyStimulus(8'hFB, codes[1], 1'b0, 3);
    end
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("sat_cnt", 0, int'(ecnt_o[0]), m_ecnt[0], 255);
    checkLiteral("sat_cnt", 1, int'(ecnt_o[1]), m_ecnt[1], 255);

    // Reset discards a partial frame.
    applyStimulus(8'hFE, codes[5], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 2);
    pulseReset();
    checkLiteral("rst2_cnt", 1, int'(ecnt_o[1]), m_ecnt[1], 0);
    applyStimulus(8'hFD, codes[9], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("part_num", 0, int'(num_o[0]), m_num[0], 0);
    checkLiteral("part_num", 1, int'(num_o[1]), m_num[1], 0);
    applyStimulus(8'hFE, codes[0], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("n90", 0, int'(num_o[0]), m_num[0], 90);
    checkLiteral("n90", 1, int'(num_o[1]), m_num[1], 90);
    applyStimulus(8'hFD, codes[9], 1'b0, 3);
    applyStimulus(8'hFE, codes[0], 1'b0, 3);
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);
    checkLiteral("rep90", 1, int'(num_o[1]), m_num[1], 90);

    // Randomised traffic.
    for (int n = 0; n < 1200; n++) begin
      int r;
      logic [7:0] a;
      logic [6:0] d;
      r = $urandom_range(0, 9);
      a = (r < 4) ? 8'hFE : (r < 8) ? 8'hFD : (r == 8) ? 8'hFF : 8'($urandom);
      d = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 9)] : 7'($urandom);
      applyStimulus(a, d, ($urandom_range(0, 15) == 0), $urandom_range(1, 4));
    end
    applyStimulus(8'hFF, 7'h7F, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
